// File: rtl/rob_pkg.sv
// rtl/rob_pkg.sv - shared reorder buffer sizing, kind codes and entry layout
package rob_pkg;

    localparam int ROB_SIZE_DEF = 8;
    localparam int ROB_BIT_DEF  = 3;

    typedef enum logic [1:0] {
        KIND_REG    = 2'd0,
        KIND_STORE  = 2'd1,
        KIND_BRANCH = 2'd2
    } rob_kind_e;

    typedef struct packed {
        logic [1:0]  kind;
        logic [4:0]  rd;
        logic [31:0] value;
        logic [31:0] pred_pc;
        logic [31:0] inst_addr;
    } rob_entry_t;

    // A branch entry whose resolved target differs from the predicted one.
    function automatic logic is_mispredict(input rob_entry_t e);
        return (e.kind == KIND_BRANCH) && (e.value != e.pred_pc);
    endfunction

endpackage

// File: rtl/rob_bypass.sv
// rtl/rob_bypass.sv - operand lookup with same-cycle broadcast forwarding
module rob_bypass #(
    parameter int ROB_BIT = 3
) (
    input  logic               bcast_en,
    input  logic [ROB_BIT-1:0] query_entry,
    input  logic               entry_ready,
    input  logic [31:0]        entry_value,
    input  logic               rs_ready,
    input  logic [ROB_BIT-1:0] rs_rob_entry,
    input  logic [31:0]        rs_value,
    input  logic               lsb_ready,
    input  logic [ROB_BIT-1:0] lsb_rob_entry,
    input  logic [31:0]        lsb_value,
    output logic               query_ready,
    output logic [31:0]        query_value
);

    // Forward a broadcast landing this cycle ahead of the stored entry; the ALU port has priority.
    always_comb begin
        query_ready = entry_ready;
        query_value = entry_value;
        if (bcast_en && rs_ready && (rs_rob_entry == query_entry)) begin
            query_ready = 1'b1;
            query_value = rs_value;
        end else if (bcast_en && lsb_ready && (lsb_rob_entry == query_entry)) begin
            query_ready = 1'b1;
            query_value = lsb_value;
        end
    end

endmodule

// File: rtl/rob.sv
// rtl/rob.sv - in-order reorder buffer with result broadcast, commit and branch flush
module rob
    import rob_pkg::*;
#(
    parameter int ROB_SIZE = ROB_SIZE_DEF,
    parameter int ROB_BIT  = ROB_BIT_DEF
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic               issue_signal,
    input  logic [1:0]         issue_kind,
    input  logic [4:0]         issue_rd,
    input  logic [31:0]        issue_pred_pc,
    input  logic [31:0]        issue_inst_addr,
    output logic [ROB_BIT-1:0] tail_entry,
    output logic               rob_full,
    input  logic               rs_ready,
    input  logic [ROB_BIT-1:0] rs_rob_entry,
    input  logic [31:0]        rs_value,
    input  logic               lsb_ready,
    input  logic [ROB_BIT-1:0] lsb_rob_entry,
    input  logic [31:0]        lsb_value,
    input  logic [ROB_BIT-1:0] query1_entry,
    input  logic [ROB_BIT-1:0] query2_entry,
    output logic               query1_ready,
    output logic               query2_ready,
    output logic [31:0]        query1_value,
    output logic [31:0]        query2_value,
    output logic               commit_reg_valid,
    output logic               commit_store_valid,
    output logic [4:0]         commit_rd,
    output logic [31:0]        commit_value,
    output logic [ROB_BIT-1:0] commit_rob_entry,
    output logic               rob_clear_up,
    output logic [31:0]        clear_pc
);

    logic [ROB_BIT-1:0]  head_q;
    logic [ROB_BIT-1:0]  tail_q;
    logic [ROB_BIT:0]    count_q;
    logic [ROB_SIZE-1:0] busy_q;
    logic [ROB_SIZE-1:0] ready_q;
    rob_entry_t          ent_q [ROB_SIZE];

    rob_entry_t head_ent;
    logic       issue_fire;
    logic       commit_fire;
    logic       flush_fire;
    logic       bcast_en;
    logic       rs_hit;
    logic       lsb_hit;
    logic       query_bcast_en;

    assign rob_full   = (count_q == (ROB_BIT + 1)'(ROB_SIZE));
    assign tail_entry = tail_q;
    assign head_ent   = ent_q[head_q];

    // Issue is refused when full and during the flush cycle; commit needs a ready head.
    assign issue_fire  = rdy_in && issue_signal && !rob_full && !rob_clear_up;
    assign commit_fire = rdy_in && busy_q[head_q] && ready_q[head_q];
    assign flush_fire  = commit_fire && is_mispredict(head_ent);

    // Broadcasts only land on live, still-pending entries and are dropped around a flush.
    assign bcast_en = rdy_in && !rob_clear_up && !flush_fire;
    assign rs_hit   = bcast_en && rs_ready && busy_q[rs_rob_entry] && !ready_q[rs_rob_entry];
    assign lsb_hit  = bcast_en && lsb_ready && busy_q[lsb_rob_entry] && !ready_q[lsb_rob_entry];

    assign query_bcast_en = !rob_clear_up;

    // Head/tail pointers wrap naturally at the power-of-two size; count tracks occupancy.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush_fire) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (issue_fire) begin
                tail_q <= tail_q + 1'b1;
            end
            if (commit_fire) begin
                head_q <= head_q + 1'b1;
            end
            case ({issue_fire, commit_fire})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Per-entry busy/ready flags: commit retires the head, broadcasts mark results, issue allocates.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            busy_q  <= '0;
            ready_q <= '0;
        end else if (flush_fire) begin
            busy_q  <= '0;
            ready_q <= '0;
        end else begin
            if (commit_fire) begin
                busy_q[head_q]  <= 1'b0;
                ready_q[head_q] <= 1'b0;
            end
            if (lsb_hit) begin
                ready_q[lsb_rob_entry] <= 1'b1;
            end
            if (rs_hit) begin
                ready_q[rs_rob_entry] <= 1'b1;
            end
            if (issue_fire) begin
                busy_q[tail_q]  <= 1'b1;
                ready_q[tail_q] <= (issue_kind == KIND_STORE);
            end
        end
    end

    // Entry payloads; the ALU write is last so it wins a same-entry collision with the LSB.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < ROB_SIZE; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            if (lsb_hit) begin
                ent_q[lsb_rob_entry].value <= lsb_value;
            end
            if (rs_hit) begin
                ent_q[rs_rob_entry].value <= rs_value;
            end
            if (issue_fire) begin
                ent_q[tail_q] <= '{kind:      issue_kind,
                                   rd:        issue_rd,
                                   value:     32'd0,
                                   pred_pc:   issue_pred_pc,
                                   inst_addr: issue_inst_addr};
            end
        end
    end

    // Registered commit and flush pulses; a stalled cycle suppresses both.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            commit_reg_valid   <= 1'b0;
            commit_store_valid <= 1'b0;
            commit_rd          <= '0;
            commit_value       <= '0;
            commit_rob_entry   <= '0;
            rob_clear_up       <= 1'b0;
            clear_pc           <= '0;
        end else if (!rdy_in) begin
            commit_reg_valid   <= 1'b0;
            commit_store_valid <= 1'b0;
            rob_clear_up       <= 1'b0;
        end else begin
            commit_reg_valid   <= commit_fire && (head_ent.kind == KIND_REG);
            commit_store_valid <= commit_fire && (head_ent.kind == KIND_STORE);
            rob_clear_up       <= flush_fire;
            if (commit_fire) begin
                commit_rd        <= head_ent.rd;
                commit_value     <= head_ent.value;
                commit_rob_entry <= head_q;
            end
            if (flush_fire) begin
                clear_pc <= head_ent.value;
            end
        end
    end

    rob_bypass #(.ROB_BIT(ROB_BIT)) u_bypass1 (
        .bcast_en      (query_bcast_en),
        .query_entry   (query1_entry),
        .entry_ready   (ready_q[query1_entry]),
        .entry_value   (ent_q[query1_entry].value),
        .rs_ready      (rs_ready),
        .rs_rob_entry  (rs_rob_entry),
        .rs_value      (rs_value),
        .lsb_ready     (lsb_ready),
        .lsb_rob_entry (lsb_rob_entry),
        .lsb_value     (lsb_value),
        .query_ready   (query1_ready),
        .query_value   (query1_value)
    );

    rob_bypass #(.ROB_BIT(ROB_BIT)) u_bypass2 (
        .bcast_en      (query_bcast_en),
        .query_entry   (query2_entry),
        .entry_ready   (ready_q[query2_entry]),
        .entry_value   (ent_q[query2_entry].value),
        .rs_ready      (rs_ready),
        .rs_rob_entry  (rs_rob_entry),
        .rs_value      (rs_value),
        .lsb_ready     (lsb_ready),
        .lsb_rob_entry (lsb_rob_entry),
        .lsb_value     (lsb_value),
        .query_ready   (query2_ready),
        .query_value   (query2_value)
    );

endmodule

// File: tb/tb_rob.sv
// tb/tb_rob.sv - self-checking bench for the reorder buffer
module tb_rob;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        issue_signal;
    logic [1:0]  issue_kind;
    logic [4:0]  issue_rd;
    logic [31:0] issue_pred_pc;
    logic [31:0] issue_inst_addr;
    logic [2:0]  tail_entry;
    logic        rob_full;
    logic        rs_ready;
    logic [2:0]  rs_rob_entry;
    logic [31:0] rs_value;
    logic        lsb_ready;
    logic [2:0]  lsb_rob_entry;
    logic [31:0] lsb_value;
    logic [2:0]  query1_entry;
    logic [2:0]  query2_entry;
    logic        query1_ready;
    logic        query2_ready;
    logic [31:0] query1_value;
    logic [31:0] query2_value;
    logic        commit_reg_valid;
    logic        commit_store_valid;
    logic [4:0]  commit_rd;
    logic [31:0] commit_value;
    logic [2:0]  commit_rob_entry;
    logic        rob_clear_up;
    logic [31:0] clear_pc;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int        idx;
        int        kind;
        bit [4:0]  rd;
        bit [31:0] val;
        bit [31:0] pred;
        bit        rdy;
    } ment_t;

    rob #(.ROB_SIZE(8), .ROB_BIT(3)) dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .rdy_in             (rdy_in),
        .issue_signal       (issue_signal),
        .issue_kind         (issue_kind),
        .issue_rd           (issue_rd),
        .issue_pred_pc      (issue_pred_pc),
        .issue_inst_addr    (issue_inst_addr),
        .tail_entry         (tail_entry),
        .rob_full           (rob_full),
        .rs_ready           (rs_ready),
        .rs_rob_entry       (rs_rob_entry),
        .rs_value           (rs_value),
        .lsb_ready          (lsb_ready),
        .lsb_rob_entry      (lsb_rob_entry),
        .lsb_value          (lsb_value),
        .query1_entry       (query1_entry),
        .query2_entry       (query2_entry),
        .query1_ready       (query1_ready),
        .query2_ready       (query2_ready),
        .query1_value       (query1_value),
        .query2_value       (query2_value),
        .commit_reg_valid   (commit_reg_valid),
        .commit_store_valid (commit_store_valid),
        .commit_rd          (commit_rd),
        .commit_value       (commit_value),
        .commit_rob_entry   (commit_rob_entry),
        .rob_clear_up       (rob_clear_up),
        .clear_pc           (clear_pc)
    );

    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle_inputs();
        rdy_in          = 1'b1;
        issue_signal    = 1'b0;
        issue_kind      = 2'd0;
        issue_rd        = 5'd0;
        issue_pred_pc   = 32'd0;
        issue_inst_addr = 32'd0;
        rs_ready        = 1'b0;
        rs_rob_entry    = 3'd0;
        rs_value        = 32'd0;
        lsb_ready       = 1'b0;
        lsb_rob_entry   = 3'd0;
        lsb_value       = 32'd0;
        query1_entry    = 3'd0;
        query2_entry    = 3'd0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
    endtask

    task automatic drive_issue(input logic [1:0] k, input logic [4:0] rd, input logic [31:0] pred);
        issue_signal    = 1'b1;
        issue_kind      = k;
        issue_rd        = rd;
        issue_pred_pc   = pred;
        issue_inst_addr = 32'h1000 + {27'd0, rd};
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_in = 1'b1;
        step();
        n_checks++;
        if (tail_entry !== 3'd0) begin n_fail++; $display("FAIL reset_tail: got %0d expected 0", tail_entry); end
        n_checks++;
        if (rob_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %0b expected 0", rob_full); end
        n_checks++;
        if ({commit_reg_valid, commit_store_valid, rob_clear_up} !== 3'b000) begin
            n_fail++; $display("FAIL reset_pulses: got %03b expected 000", {commit_reg_valid, commit_store_valid, rob_clear_up});
        end
        n_checks++;
        if (query1_ready !== 1'b0) begin n_fail++; $display("FAIL reset_query: got %0b expected 0", query1_ready); end
        rst_in = 1'b0;
    endtask

    task automatic test_fill();
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            drive_issue(2'd0, 5'(i + 1), 32'd0);
            n_checks++;
            if (tail_entry !== 3'(i)) begin n_fail++; $display("FAIL fill_tail: got %0d expected %0d", tail_entry, i); end
            n_checks++;
            if (rob_full !== 1'b0) begin n_fail++; $display("FAIL fill_not_full: got %0b expected 0 at %0d", rob_full, i); end
            step();
        end
        issue_signal = 1'b0;
        n_checks++;
        if (tail_entry !== 3'd0) begin n_fail++; $display("FAIL fill_wrap: got %0d expected 0", tail_entry); end
        n_checks++;
        if (rob_full !== 1'b1) begin n_fail++; $display("FAIL fill_full: got %0b expected 1", rob_full); end
        drive_issue(2'd0, 5'd9, 32'd0);
        step();
        issue_signal = 1'b0;
        n_checks++;
        if (tail_entry !== 3'd0 || rob_full !== 1'b1) begin
            n_fail++; $display("FAIL fill_ninth_ignored: got tail %0d full %0b expected tail 0 full 1", tail_entry, rob_full);
        end
    endtask

    task automatic test_basic_commit();
        apply_reset();
        drive_issue(2'd0, 5'd5, 32'd0);
        step();
        issue_signal = 1'b0;
        rs_ready = 1'b1; rs_rob_entry = 3'd0; rs_value = 32'h1234;
        step();
        rs_ready = 1'b0;
        n_checks++;
        if (commit_reg_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early: got %0b expected 0", commit_reg_valid); end
        step();
        n_checks++;
        if (commit_reg_valid !== 1'b1 || commit_rd !== 5'd5 || commit_value !== 32'h1234 || commit_rob_entry !== 3'd0) begin
            n_fail++; $display("FAIL basic_commit: got v%0b rd%0d val%0h e%0d expected v1 rd5 val1234 e0",
                               commit_reg_valid, commit_rd, commit_value, commit_rob_entry);
        end
        step();
        n_checks++;
        if (commit_reg_valid !== 1'b0) begin n_fail++; $display("FAIL basic_pulse: got %0b expected 0", commit_reg_valid); end
    endtask

    task automatic test_in_order();
        apply_reset();
        drive_issue(2'd0, 5'd1, 32'd0);
        step();
        drive_issue(2'd0, 5'd2, 32'd0);
        step();
        issue_signal = 1'b0;
        rs_ready = 1'b1; rs_rob_entry = 3'd1; rs_value = 32'h11;
        step();
        rs_ready = 1'b0;
        step();
        n_checks++;
        if (commit_reg_valid !== 1'b0) begin n_fail++; $display("FAIL order_hold: got %0b expected 0", commit_reg_valid); end
        lsb_ready = 1'b1; lsb_rob_entry = 3'd0; lsb_value = 32'h22;
        step();
        lsb_ready = 1'b0;
        n_checks++;
        if (commit_reg_valid !== 1'b0) begin n_fail++; $display("FAIL order_latency: got %0b expected 0", commit_reg_valid); end
        step();
        n_checks++;
        if (commit_reg_valid !== 1'b1 || commit_rob_entry !== 3'd0 || commit_value !== 32'h22 || commit_rd !== 5'd1) begin
            n_fail++; $display("FAIL order_first: got v%0b e%0d val%0h rd%0d expected v1 e0 val22 rd1",
                               commit_reg_valid, commit_rob_entry, commit_value, commit_rd);
        end
        step();
        n_checks++;
        if (commit_reg_valid !== 1'b1 || commit_rob_entry !== 3'd1 || commit_value !== 32'h11 || commit_rd !== 5'd2) begin
            n_fail++; $display("FAIL order_second: got v%0b e%0d val%0h rd%0d expected v1 e1 val11 rd2",
                               commit_reg_valid, commit_rob_entry, commit_value, commit_rd);
        end
        step();
        n_checks++;
        if (commit_reg_valid !== 1'b0) begin n_fail++; $display("FAIL order_done: got %0b expected 0", commit_reg_valid); end
    endtask

    task automatic test_branch();
        apply_reset();
        drive_issue(2'd2, 5'd0, 32'h100);
        step();
        issue_signal = 1'b0;
        rs_ready = 1'b1; rs_rob_entry = 3'd0; rs_value = 32'h200;
        step();
        rs_ready = 1'b0;
        step();
        n_checks++;
        if (rob_clear_up !== 1'b1 || clear_pc !== 32'h200) begin
            n_fail++; $display("FAIL mispredict_flush: got clr%0b pc%0h expected clr1 pc200", rob_clear_up, clear_pc);
        end
        n_checks++;
        if (commit_reg_valid !== 1'b0 || commit_store_valid !== 1'b0 || tail_entry !== 3'd0) begin
            n_fail++; $display("FAIL mispredict_state: got r%0b s%0b t%0d expected r0 s0 t0",
                               commit_reg_valid, commit_store_valid, tail_entry);
        end
        drive_issue(2'd0, 5'd7, 32'd0);
        step();
        issue_signal = 1'b0;
        n_checks++;
        if (rob_clear_up !== 1'b0 || tail_entry !== 3'd0 || rob_full !== 1'b0) begin
            n_fail++; $display("FAIL mispredict_after: got clr%0b t%0d f%0b expected clr0 t0 f0", rob_clear_up, tail_entry, rob_full);
        end
        drive_issue(2'd2, 5'd0, 32'h40);
        step();
        issue_signal = 1'b0;
        rs_ready = 1'b1; rs_rob_entry = 3'd0; rs_value = 32'h40;
        step();
        rs_ready = 1'b0;
        drive_issue(2'd1, 5'd3, 32'd0);
        step();
        issue_signal = 1'b0;
        n_checks++;
        if (rob_clear_up !== 1'b0 || commit_reg_valid !== 1'b0 || commit_store_valid !== 1'b0 || tail_entry !== 3'd2) begin
            n_fail++; $display("FAIL predicted_branch: got clr%0b r%0b s%0b t%0d expected clr0 r0 s0 t2",
                               rob_clear_up, commit_reg_valid, commit_store_valid, tail_entry);
        end
        step();
        n_checks++;
        if (commit_store_valid !== 1'b1 || commit_rob_entry !== 3'd1 || commit_reg_valid !== 1'b0) begin
            n_fail++; $display("FAIL store_commit: got s%0b e%0d r%0b expected s1 e1 r0",
                               commit_store_valid, commit_rob_entry, commit_reg_valid);
        end
    endtask

    task automatic test_query_bypass();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            drive_issue(2'd0, 5'(i + 1), 32'd0);
            step();
        end
        issue_signal = 1'b0;
        query1_entry = 3'd2; query2_entry = 3'd1;
        lsb_ready = 1'b1; lsb_rob_entry = 3'd2; lsb_value = 32'hAB;
        #1;
        n_checks++;
        if (query1_ready !== 1'b1 || query1_value !== 32'hAB) begin
            n_fail++; $display("FAIL query_lsb_bypass: got r%0b v%0h expected r1 vab", query1_ready, query1_value);
        end
        n_checks++;
        if (query2_ready !== 1'b0) begin n_fail++; $display("FAIL query_other: got %0b expected 0", query2_ready); end
        rs_ready = 1'b1; rs_rob_entry = 3'd2; rs_value = 32'hCD;
        #1;
        n_checks++;
        if (query1_ready !== 1'b1 || query1_value !== 32'hCD) begin
            n_fail++; $display("FAIL query_rs_priority: got r%0b v%0h expected r1 vcd", query1_ready, query1_value);
        end
        step();
        rs_ready = 1'b0; lsb_ready = 1'b0;
        #1;
        n_checks++;
        if (query1_ready !== 1'b1 || query1_value !== 32'hCD) begin
            n_fail++; $display("FAIL query_stored: got r%0b v%0h expected r1 vcd", query1_ready, query1_value);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            drive_issue(2'd0, 5'(i + 4), 32'd0);
            step();
        end
        issue_signal = 1'b0;
        rs_ready = 1'b1; rs_rob_entry = 3'd0; rs_value = 32'h55;
        step();
        rs_ready = 1'b0;
        query1_entry = 3'd1;
        step();
        n_checks++;
        if (commit_reg_valid !== 1'b1 || tail_entry !== 3'd5) begin
            n_fail++; $display("FAIL areset_pre: got v%0b t%0d expected v1 t5", commit_reg_valid, tail_entry);
        end
        #2;
        rst_in = 1'b1;
        #1;
        n_checks++;
        if (commit_reg_valid !== 1'b0 || commit_value !== 32'd0 || commit_rd !== 5'd0 || commit_rob_entry !== 3'd0) begin
            n_fail++; $display("FAIL areset_commit: got v%0b val%0h rd%0d e%0d expected all 0",
                               commit_reg_valid, commit_value, commit_rd, commit_rob_entry);
        end
        n_checks++;
        if (tail_entry !== 3'd0 || rob_full !== 1'b0 || query1_ready !== 1'b0 || query1_value !== 32'd0) begin
            n_fail++; $display("FAIL areset_state: got t%0d f%0b qr%0b qv%0h expected all 0",
                               tail_entry, rob_full, query1_ready, query1_value);
        end
        step();
        rst_in = 1'b0;
    endtask

    task automatic test_random();
        ment_t     mq[$];
        int        pend[$];
        int        tail;
        bit        flush;
        bit        e_reg, e_store, e_clear;
        bit [4:0]  e_rd;
        bit [31:0] e_val, e_cpc;
        int        e_ent;
        int        lh, rh, qe, k;
        bit        old_full, old_flush, commit_now, exp_rdy, act_rdy;
        bit [31:0] exp_val, act_val;
        ment_t     ne;

        apply_reset();
        tail = 0; flush = 0; e_reg = 0; e_store = 0; e_clear = 0;
        e_rd = 0; e_val = 0; e_cpc = 0; e_ent = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            n_checks++;
            if (commit_reg_valid !== e_reg || commit_store_valid !== e_store || rob_clear_up !== e_clear) begin
                n_fail++; $display("FAIL rand_pulses cyc %0d: got r%0b s%0b c%0b expected r%0b s%0b c%0b", cyc,
                                   commit_reg_valid, commit_store_valid, rob_clear_up, e_reg, e_store, e_clear);
            end
            if (e_reg || e_store) begin
                n_checks++;
                if (commit_rd !== e_rd || commit_value !== e_val || commit_rob_entry !== 3'(e_ent)) begin
                    n_fail++; $display("FAIL rand_commit cyc %0d: got rd%0d v%0h e%0d expected rd%0d v%0h e%0d", cyc,
                                       commit_rd, commit_value, commit_rob_entry, e_rd, e_val, e_ent);
                end
            end
            if (e_clear) begin
                n_checks++;
                if (clear_pc !== e_cpc) begin
                    n_fail++; $display("FAIL rand_clear_pc cyc %0d: got %0h expected %0h", cyc, clear_pc, e_cpc);
                end
            end
            n_checks++;
            if (tail_entry !== 3'(tail) || rob_full !== (mq.size() == 8)) begin
                n_fail++; $display("FAIL rand_occupancy cyc %0d: got t%0d f%0b expected t%0d f%0b", cyc,
                                   tail_entry, rob_full, tail, mq.size() == 8);
            end

            rdy_in          = ($urandom_range(0, 7) != 0);
            issue_signal    = $urandom_range(0, 1);
            issue_kind      = 2'($urandom_range(0, 2));
            issue_rd        = 5'($urandom_range(0, 31));
            issue_pred_pc   = $urandom_range(0, 1) ? 32'h100 : 32'h200;
            issue_inst_addr = $urandom;
            query1_entry    = 3'($urandom_range(0, 7));
            query2_entry    = 3'($urandom_range(0, 7));
            pend.delete();
            for (int i = 0; i < mq.size(); i++) if (!mq[i].rdy) pend.push_back(i);
            rs_ready = 1'b0; lsb_ready = 1'b0;
            rs_rob_entry = 3'($urandom_range(0, 7)); lsb_rob_entry = 3'($urandom_range(0, 7));
            rs_value = $urandom; lsb_value = $urandom;
            if (pend.size() > 0 && $urandom_range(0, 2) != 0) begin
                k = pend[$urandom_range(0, pend.size() - 1)];
                rs_ready = 1'b1; rs_rob_entry = 3'(mq[k].idx);
                if ($urandom_range(0, 1) != 0) rs_value = mq[k].pred;
            end
            if (pend.size() > 0 && $urandom_range(0, 2) == 0) begin
                k = pend[$urandom_range(0, pend.size() - 1)];
                lsb_ready = 1'b1; lsb_rob_entry = 3'(mq[k].idx);
                if ($urandom_range(0, 1) != 0) lsb_value = mq[k].pred;
            end
            #1;

            for (int qn = 0; qn < 2; qn++) begin
                qe      = (qn == 0) ? int'(query1_entry) : int'(query2_entry);
                act_rdy = (qn == 0) ? query1_ready : query2_ready;
                act_val = (qn == 0) ? query1_value : query2_value;
                exp_rdy = 1'b0; exp_val = 32'd0;
                if (!flush && rs_ready && int'(rs_rob_entry) == qe) begin
                    exp_rdy = 1'b1; exp_val = rs_value;
                end else if (!flush && lsb_ready && int'(lsb_rob_entry) == qe) begin
                    exp_rdy = 1'b1; exp_val = lsb_value;
                end else begin
                    for (int i = 0; i < mq.size(); i++) begin
                        if (mq[i].idx == qe) begin exp_rdy = mq[i].rdy; exp_val = mq[i].val; end
                    end
                end
                n_checks++;
                if (act_rdy !== exp_rdy || (exp_rdy && act_val !== exp_val)) begin
                    n_fail++; $display("FAIL rand_query%0d cyc %0d entry %0d: got r%0b v%0h expected r%0b v%0h",
                                       qn + 1, cyc, qe, act_rdy, act_val, exp_rdy, exp_val);
                end
            end

            if (!rdy_in) begin
                e_reg = 0; e_store = 0; e_clear = 0; flush = 0;
            end else begin
                old_full  = (mq.size() == 8);
                old_flush = flush;
                lh = -1; rh = -1;
                if (!old_flush) begin
                    for (int i = 0; i < mq.size(); i++) begin
                        if (lsb_ready && mq[i].idx == int'(lsb_rob_entry) && !mq[i].rdy) lh = i;
                        if (rs_ready && mq[i].idx == int'(rs_rob_entry) && !mq[i].rdy) rh = i;
                    end
                end
                e_reg = 0; e_store = 0; e_clear = 0;
                commit_now = (mq.size() > 0) && mq[0].rdy;
                if (commit_now) begin
                    e_ent = mq[0].idx; e_rd = mq[0].rd; e_val = mq[0].val;
                    e_reg = (mq[0].kind == 0); e_store = (mq[0].kind == 1);
                    if (mq[0].kind == 2 && mq[0].val != mq[0].pred) begin
                        e_clear = 1; e_cpc = mq[0].val;
                    end
                end
                if (e_clear) begin
                    mq.delete(); tail = 0;
                end else begin
                    if (lh >= 0) begin mq[lh].rdy = 1; mq[lh].val = lsb_value; end
                    if (rh >= 0) begin mq[rh].rdy = 1; mq[rh].val = rs_value; end
                    if (commit_now) void'(mq.pop_front());
                    if (issue_signal && !old_full && !old_flush) begin
                        ne.idx = tail; ne.kind = int'(issue_kind); ne.rd = issue_rd;
                        ne.val = 32'd0; ne.pred = issue_pred_pc; ne.rdy = (issue_kind == 2'd1);
                        mq.push_back(ne);
                        tail = (tail + 1) % 8;
                    end
                end
                flush = e_clear;
            end
            step();
        end
        idle_inputs();
    endtask

    initial begin
        rst_in = 1'b1;
        idle_inputs();
        test_reset();
        test_fill();
        test_basic_commit();
        test_in_order();
        test_branch();
        test_query_bypass();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
